// File: rtl/instruction_sequencer.sv
// Four-state instruction sequencer: fetches a 16-bit word, decodes it into datapath
// control fields for one EXEC cycle, and advances, branches or jumps the program counter.
module instruction_sequencer #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Run,
    input  logic [15:0]   IR,
    input  logic [DW-1:0] RA,
    input  logic          Z,
    input  logic          N,
    output logic [AW-1:0] Address,
    output logic [2:0]    DA,
    output logic [2:0]    AA,
    output logic [2:0]    BA,
    output logic [4:0]    FS,
    output logic          MB,
    output logic          MD,
    output logic          RW,
    output logic          MW,
    output logic [DW-1:0] Imm,
    output logic          Halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [15:0] HALT_WORD = 16'h00FF;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;

    logic          exec_active;
    logic          is_branch;
    logic          is_jmp;
    logic          br_taken;
    logic [5:0]    br_off;
    logic [AW-1:0] br_off_ext;
    logic [AW-1:0] pc_inc;

    assign exec_active = (state_q == EXEC);
    assign is_branch   = (ir_q[15:14] == 2'b11);
    assign is_jmp      = is_branch & ir_q[13];
    assign br_taken    = is_branch & ~ir_q[13] & (ir_q[9] ? N : Z);
    assign br_off      = {ir_q[8:6], ir_q[2:0]};
    assign br_off_ext  = AW'($signed(br_off));
    assign pc_inc      = pc_q + AW'(1);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // A Run drop during FETCH or EXEC lets the instruction complete, then parks in IDLE.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            IDLE: begin
                if (Run) state_d = FETCH;
            end
            FETCH: begin
                ir_d    = IR;
                state_d = EXEC;
            end
            EXEC: begin
                if (is_jmp) begin
                    pc_d = RA[AW-1:0];
                end else if (br_taken) begin
                    pc_d = pc_q + br_off_ext;
                end else begin
                    pc_d = pc_inc;
                end
                if (ir_q == HALT_WORD) begin
                    state_d = HALT;
                end else if (Run) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                if (!Run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Decoded fields are only visible during EXEC; branches never write.
    always_comb begin
        Address = pc_q;
        Halted  = (state_q == HALT);
        DA      = '0;
        AA      = '0;
        BA      = '0;
        FS      = '0;
        MB      = 1'b0;
        MD      = 1'b0;
        RW      = 1'b0;
        MW      = 1'b0;
        Imm     = '0;
        if (exec_active) begin
            DA  = ir_q[8:6];
            AA  = ir_q[5:3];
            BA  = ir_q[2:0];
            FS  = ir_q[13:9];
            MB  = ir_q[15] & ~ir_q[14];
            MD  = ir_q[13] & ~ir_q[15] & ~ir_q[14];
            RW  = ~ir_q[14] & ~is_branch;
            MW  = ~ir_q[15] & ir_q[14] & ~is_branch;
            Imm = {{(DW-3){1'b0}}, ir_q[2:0]};
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: stimulus queues the expected EXEC-cycle
// decode and follow-on address, a monitor checks them whenever the DUT executes.
module tb_instruction_sequencer;

    logic        Clock;
    logic        Resetn;
    logic        Run;
    logic [15:0] IR;
    logic [7:0]  RA;
    logic        Z;
    logic        N;
    logic [7:0]  Address;
    logic [2:0]  DA, AA, BA;
    logic [4:0]  FS;
    logic        MB, MD, RW, MW;
    logic [7:0]  Imm;
    logic        Halted;

    logic [15:0] mem [256];

    typedef struct {
        logic [7:0] pc;
        logic [2:0] da, aa, ba;
        logic [4:0] fs;
        logic       mb, md, rw, mw;
        logic [7:0] imm;
        logic [7:0] nextPc;
    } expT;

    expT expQ[$];
    int  checkCount = 0;
    int  failCount  = 0;

    instruction_sequencer #(.AW(8), .DW(8)) dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR), .RA(RA), .Z(Z), .N(N),
        .Address(Address), .DA(DA), .AA(AA), .BA(BA), .FS(FS),
        .MB(MB), .MD(MD), .RW(RW), .MW(MW), .Imm(Imm), .Halted(Halted)
    );

    assign IR = mem[Address];

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rstnVal, input logic runVal);
        Resetn = rstnVal;
        Run    = runVal;
    endtask

    task automatic pushExp(input logic [7:0] pc, input logic [2:0] da, input logic [2:0] aa,
                           input logic [2:0] ba, input logic [4:0] fs, input logic mb,
                           input logic md, input logic rw, input logic mw,
                           input logic [7:0] imm, input logic [7:0] nextPc);
        expT e;
        e.pc = pc; e.da = da; e.aa = aa; e.ba = ba; e.fs = fs;
        e.mb = mb; e.md = md; e.rw = rw; e.mw = mw; e.imm = imm; e.nextPc = nextPc;
        expQ.push_back(e);
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic waitAddr(input logic [7:0] a, input string name);
        int n = 0;
        while (Address !== a && n < 300) begin
            @(negedge Clock);
            n++;
        end
        checkOutput(name, Address, a);
    endtask

    task automatic waitHalted();
        int n = 0;
        while (Halted !== 1'b1 && n < 300) begin
            @(negedge Clock);
            n++;
        end
        checkOutput("halt_reached", Halted, 1);
    endtask

    // Monitor: every EXEC cycle pops one expectation, then checks the address that follows.
    initial begin
        expT e;
        forever begin
            @(negedge Clock);
            if (dut.exec_active === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_exec: got EXEC at Address %0h, expected no EXEC", Address);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("exec_addr", Address, e.pc);
                    checkOutput("exec_fields", {DA, AA, BA, FS}, {e.da, e.aa, e.ba, e.fs});
                    checkOutput("exec_ctrl", {MB, MD, RW, MW}, {e.mb, e.md, e.rw, e.mw});
                    checkOutput("exec_imm", Imm, e.imm);
                    @(negedge Clock);
                    checkOutput("next_addr", Address, e.nextPc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0);
        RA = 8'h20;
        Z  = 1'b1;
        N  = 1'b0;

        // Straight-line code, branches, JMP and HALT.
        clearMem();
        mem[8'h00] = 16'h2000;
        mem[8'h01] = 16'h98C4;
        mem[8'h02] = 16'h4011;
        mem[8'h03] = 16'h0B77;
        mem[8'h04] = 16'hC040;
        mem[8'h0C] = 16'hC3C6;
        mem[8'h0D] = 16'hC1C2;
        mem[8'h07] = 16'hE000;
        mem[8'h20] = 16'h00FF;
        #12;
        checkOutput("reset_addr", Address, 0);
        checkOutput("reset_ctrl", {RW, MW, MB, MD, Halted}, 0);
        checkOutput("reset_fields", {DA, AA, BA, FS, Imm}, 0);
        pushExp(8'h00, 3'd0, 3'd0, 3'd0, 5'h10, 0, 1, 1, 0, 8'h00, 8'h01);
        pushExp(8'h01, 3'd3, 3'd0, 3'd4, 5'h0C, 1, 0, 1, 0, 8'h04, 8'h02);
        pushExp(8'h02, 3'd0, 3'd2, 3'd1, 5'h00, 0, 0, 0, 1, 8'h01, 8'h03);
        pushExp(8'h03, 3'd5, 3'd6, 3'd7, 5'h05, 0, 0, 1, 0, 8'h07, 8'h04);
        pushExp(8'h04, 3'd1, 3'd0, 3'd0, 5'h00, 0, 0, 0, 0, 8'h00, 8'h0C);
        pushExp(8'h0C, 3'd7, 3'd0, 3'd6, 5'h01, 0, 0, 0, 0, 8'h06, 8'h0D);
        pushExp(8'h0D, 3'd7, 3'd0, 3'd2, 5'h00, 0, 0, 0, 0, 8'h02, 8'h07);
        pushExp(8'h07, 3'd0, 3'd0, 3'd0, 5'h10, 0, 0, 0, 0, 8'h00, 8'h20);
        pushExp(8'h20, 3'd3, 3'd7, 3'd7, 5'h00, 0, 0, 1, 0, 8'h07, 8'h21);
        @(negedge Clock);
        applyStimulus(1'b1, 1'b1);
        waitHalted();
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            checkOutput("halt_hold_addr", Address, 8'h21);
            checkOutput("halt_no_write", {Halted, RW, MW}, 3'b100);
        end
        applyStimulus(1'b1, 1'b0);
        @(negedge Clock);
        checkOutput("halt_to_idle", Halted, 0);
        checkOutput("idle_addr", Address, 8'h21);
        checkOutput("queue_drained_a", expQ.size(), 0);

        // Negative wrap below 0, positive wrap past FF, and Run drop during FETCH.
        applyStimulus(1'b0, 1'b0);
        clearMem();
        mem[8'h00] = 16'hC1C5;
        mem[8'hFD] = 16'h2000;
        mem[8'hFE] = 16'h98C4;
        mem[8'hFF] = 16'h0B77;
        #1;
        checkOutput("reset2_addr", Address, 0);
        pushExp(8'h00, 3'd7, 3'd0, 3'd5, 5'h00, 0, 0, 0, 0, 8'h05, 8'hFD);
        pushExp(8'hFD, 3'd0, 3'd0, 3'd0, 5'h10, 0, 1, 1, 0, 8'h00, 8'hFE);
        pushExp(8'hFE, 3'd3, 3'd0, 3'd4, 5'h0C, 1, 0, 1, 0, 8'h04, 8'hFF);
        pushExp(8'hFF, 3'd5, 3'd6, 3'd7, 5'h05, 0, 0, 1, 0, 8'h07, 8'h00);
        @(negedge Clock);
        applyStimulus(1'b1, 1'b1);
        waitAddr(8'hFF, "reach_ff");
        applyStimulus(1'b1, 1'b0);
        repeat (6) @(negedge Clock);
        checkOutput("run_drop_idle_addr", Address, 8'h00);
        checkOutput("run_drop_idle_ctrl", {Halted, RW, MW}, 0);
        checkOutput("queue_drained_b", expQ.size(), 0);

        // Reset pulse in the middle of a store's EXEC cycle.
        applyStimulus(1'b0, 1'b0);
        clearMem();
        mem[8'h00] = 16'h2000;
        mem[8'h01] = 16'h4011;
        pushExp(8'h00, 3'd0, 3'd0, 3'd0, 5'h10, 0, 1, 1, 0, 8'h00, 8'h01);
        @(negedge Clock);
        applyStimulus(1'b1, 1'b1);
        waitAddr(8'h01, "reach_store");
        @(posedge Clock);
        #2;
        checkOutput("store_mw_high", MW, 1);
        applyStimulus(1'b0, 1'b1);
        #1;
        checkOutput("reset_drops_mw", {MW, RW}, 0);
        checkOutput("reset_pc_zero", Address, 0);
        checkOutput("reset_not_halted", Halted, 0);
        repeat (2) @(negedge Clock);
        pushExp(8'h00, 3'd0, 3'd0, 3'd0, 5'h10, 0, 1, 1, 0, 8'h00, 8'h01);
        pushExp(8'h01, 3'd0, 3'd2, 3'd1, 5'h00, 0, 0, 0, 1, 8'h01, 8'h02);
        applyStimulus(1'b1, 1'b1);
        waitAddr(8'h01, "resume_store");
        applyStimulus(1'b1, 1'b0);
        repeat (6) @(negedge Clock);
        checkOutput("resume_final_addr", Address, 8'h02);
        checkOutput("queue_drained_c", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
